// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module : fft_frame_sequencer
// Brief  : Ping-pong capture of mic samples, frame streaming to the FFT core
//          and peak search over the returned bin magnitudes.
// Rev    : 1.0
// ============================================================================
module fft_frame_sequencer #(
    parameter int FRAME_LEN = 64,
    parameter int DATA_W    = 12,
    parameter int MAG_W     = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            mic_data,
    input  logic                         mic_valid,
    output logic [DATA_W-1:0]            fft_in_data,
    output logic                         fft_in_valid,
    output logic                         fft_in_last,
    input  logic                         fft_in_ready,
    input  logic [MAG_W-1:0]             fft_out_mag,
    input  logic                         fft_out_valid,
    input  logic                         fft_out_last,
    output logic [$clog2(FRAME_LEN)-1:0] peak_bin,
    output logic [MAG_W-1:0]             peak_mag,
    output logic                         peak_valid,
    output logic                         overrun,
    output logic                         frame_err,
    output logic                         busy
);
    localparam int               BIN_W    = $clog2(FRAME_LEN);
    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(FRAME_LEN - 1);
    localparam logic [BIN_W-1:0] HALF_IDX = BIN_W'(FRAME_LEN / 2);
    localparam logic [BIN_W-1:0] ONE_IDX  = BIN_W'(1);
    localparam logic [BIN_W-1:0] ZERO_IDX = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_STREAM  = 2'd1,
        S_COLLECT = 2'd2
    } state_t;

    state_t             state_q;
    logic [DATA_W-1:0]  buf_q [0:2*FRAME_LEN-1];
    logic               cap_sel_q;
    logic [BIN_W-1:0]   wr_idx_q;
    logic [BIN_W-1:0]   rd_idx_q;
    logic [BIN_W-1:0]   bin_idx_q;
    logic [BIN_W-1:0]   max_bin_q;
    logic [MAG_W-1:0]   max_mag_q;
    logic [DATA_W-1:0]  in_data_q;
    logic               in_valid_q;
    logic               in_last_q;
    logic [BIN_W-1:0]   peak_bin_q;
    logic [MAG_W-1:0]   peak_mag_q;
    logic               peak_valid_q;
    logic               overrun_q;
    logic               frame_err_q;

    logic               frame_done_d;
    logic               release_d;
    logic               accept_d;
    logic               hs_d;
    logic [BIN_W-1:0]   rd_idx_d;

    // The stream buffer is always the one not being captured into, so a single
    // select bit addresses both halves of the ping-pong store.
    always_comb begin
        frame_done_d = mic_valid && (wr_idx_q == LAST_IDX);
        release_d    = (state_q == S_COLLECT) && fft_out_valid &&
                       ((bin_idx_q == LAST_IDX) || fft_out_last);
        accept_d     = frame_done_d && ((state_q == S_IDLE) || release_d);
        hs_d         = (state_q == S_STREAM) && in_valid_q && fft_in_ready;
        rd_idx_d     = rd_idx_q + ONE_IDX;
    end

    always_ff @(posedge clk) begin
        if (mic_valid) begin
            buf_q[{cap_sel_q, wr_idx_q}] <= mic_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cap_sel_q    <= 1'b0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            bin_idx_q    <= '0;
            max_bin_q    <= '0;
            max_mag_q    <= '0;
            in_data_q    <= '0;
            in_valid_q   <= 1'b0;
            in_last_q    <= 1'b0;
            peak_bin_q   <= '0;
            peak_mag_q   <= '0;
            peak_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;

            if (mic_valid) begin
                wr_idx_q <= wr_idx_q + ONE_IDX;
            end
            if (frame_done_d && !accept_d) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                S_STREAM: begin
                    if (hs_d) begin
                        if (in_last_q) begin
                            in_valid_q <= 1'b0;
                            in_last_q  <= 1'b0;
                            bin_idx_q  <= '0;
                            max_bin_q  <= ONE_IDX;
                            max_mag_q  <= '0;
                            state_q    <= S_COLLECT;
                        end else begin
                            rd_idx_q  <= rd_idx_d;
                            in_data_q <= buf_q[{~cap_sel_q, rd_idx_d}];
                            in_last_q <= (rd_idx_d == LAST_IDX);
                        end
                    end
                end
                S_COLLECT: begin
                    if (fft_out_valid) begin
                        bin_idx_q <= bin_idx_q + ONE_IDX;
                        if (bin_idx_q == LAST_IDX) begin
                            if (fft_out_last) begin
                                peak_bin_q   <= max_bin_q;
                                peak_mag_q   <= max_mag_q;
                                peak_valid_q <= 1'b1;
                            end else begin
                                frame_err_q  <= 1'b1;
                            end
                            state_q <= S_IDLE;
                        end else if (fft_out_last) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_IDLE;
                        end else if ((bin_idx_q != ZERO_IDX) && (bin_idx_q < HALF_IDX) &&
                                     (fft_out_mag > max_mag_q)) begin
                            // Strict compare keeps the lowest index on ties.
                            max_bin_q <= bin_idx_q;
                            max_mag_q <= fft_out_mag;
                        end
                    end
                end
                default: begin
                end
            endcase

            // A frame completing as the stream buffer is released starts the
            // next stream directly, overriding the return to idle above.
            if (accept_d) begin
                cap_sel_q  <= ~cap_sel_q;
                rd_idx_q   <= '0;
                in_data_q  <= buf_q[{cap_sel_q, ZERO_IDX}];
                in_valid_q <= 1'b1;
                in_last_q  <= 1'b0;
                state_q    <= S_STREAM;
            end
        end
    end

    assign fft_in_data  = in_data_q;
    assign fft_in_valid = in_valid_q;
    assign fft_in_last  = in_last_q;
    assign peak_bin     = peak_bin_q;
    assign peak_mag     = peak_mag_q;
    assign peak_valid   = peak_valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = frame_err_q;
    assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire
